// File: rtl/conv_pkg.sv
// Shared types, widths and arithmetic helpers for the convolution MAC engine.
package conv_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned WEIGHT_W = 8;
   localparam int unsigned ACC_W    = 24;
   localparam int unsigned OUT_W    = 16;
   localparam int unsigned NUM_CH   = 4;
   localparam int unsigned MAX_TAPS = 49;
   localparam int unsigned TAP_W    = 6;
   localparam int unsigned CH_W     = $clog2(NUM_CH);
   localparam int unsigned PROD_W   = DATA_W + 1 + WEIGHT_W;

   localparam int unsigned TAPS_3X3 = 9;
   localparam int unsigned TAPS_5X5 = 25;
   localparam int unsigned TAPS_7X7 = 49;

   typedef enum logic [1:0] {
      KS_3X3 = 2'b00,
      KS_5X5 = 2'b01,
      KS_7X7 = 2'b10,
      KS_BAD = 2'b11
   } ks_e;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      OUTPUT
   } state_e;

   typedef struct packed {
      logic [CH_W-1:0]            ch;
      logic [TAP_W-1:0]           addr;
      logic signed [WEIGHT_W-1:0] data;
   } weight_wr_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   function automatic logic [TAP_W-1:0] ks_taps(input ks_e ks);
      case (ks)
         KS_5X5:  return TAP_W'(TAPS_5X5);
         KS_7X7:  return TAP_W'(TAPS_7X7);
         default: return TAP_W'(TAPS_3X3);
      endcase
   endfunction

   // Clamp a full-width accumulator into the signed output range.
   function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
      if (v > SAT_MAX) begin
         return OUT_W'(SAT_MAX);
      end else if (v < SAT_MIN) begin
         return OUT_W'(SAT_MIN);
      end else begin
         return OUT_W'(v);
      end
   endfunction

endpackage

// File: rtl/mac_lane.sv
// One output channel: multiply, accumulate, and saturate (optional ReLU via CONV_RELU_EN).
module mac_lane
   import conv_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       en,
   input  logic                       load,
   input  logic [DATA_W-1:0]          pixel,
   input  logic signed [WEIGHT_W-1:0] weight,
   output logic signed [OUT_W-1:0]    result
);

   logic signed [PROD_W-1:0] prod_c;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_next_c;
   logic signed [OUT_W-1:0]  lane_out_c;

   assign prod_c     = PROD_W'($signed({1'b0, pixel})) * PROD_W'(weight);
   assign acc_next_c = acc + ACC_W'(prod_c);

   // The result is taken from the sum including the final tap so it is ready on OUTPUT entry.
   always_comb begin
      lane_out_c = saturate(acc_next_c);
`ifdef CONV_RELU_EN
      if (lane_out_c[OUT_W-1]) begin
         lane_out_c = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= '0;
         result <= '0;
      end else begin
         if (clear) begin
            acc <= '0;
         end else if (en) begin
            acc <= acc_next_c;
         end
         if (load) begin
            result <= lane_out_c;
         end
      end
   end

endmodule

// File: rtl/conv_mac_engine.sv
// Streaming multi-channel convolution MAC: FSM, tap counter, weight store and handshakes.
// Optional build macro CONV_RELU_EN clamps negative lane results to zero.
module conv_mac_engine
   import conv_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 kernel_size,
   input  logic                       start,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          pixel_in,
   input  logic                       w_we,
   input  logic [CH_W-1:0]            w_ch,
   input  logic [TAP_W-1:0]           w_addr,
   input  logic [WEIGHT_W-1:0]        w_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_CH*OUT_W-1:0]    out_data,
   output logic                       busy,
   output logic                       cfg_err
);

   state_e                     state;
   state_e                     next_state;
   logic [TAP_W-1:0]           tap_cnt;
   logic [TAP_W-1:0]           taps;
   logic signed [WEIGHT_W-1:0] wmem [NUM_CH][MAX_TAPS];
   weight_wr_t                 wr_c;
   logic                       start_ok_c;
   logic                       start_bad_c;
   logic                       accept_c;
   logic                       last_c;
   logic                       wr_ok_c;
   logic                       wr_bad_c;

   assign wr_c     = '{ch: w_ch, addr: w_addr, data: w_data};
   assign wr_ok_c  = w_we && (state == IDLE) && (wr_c.addr < TAP_W'(MAX_TAPS));
   assign wr_bad_c = w_we && !wr_ok_c;

   // Next-state and per-cycle control strobes.
   always_comb begin
      next_state  = state;
      start_ok_c  = 1'b0;
      start_bad_c = 1'b0;
      accept_c    = 1'b0;
      last_c      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (ks_e'(kernel_size) == KS_BAD) begin
                  start_bad_c = 1'b1;
               end else begin
                  start_ok_c = 1'b1;
                  next_state = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (in_valid && in_ready) begin
               accept_c = 1'b1;
               if (tap_cnt == taps - TAP_W'(1)) begin
                  last_c     = 1'b1;
                  next_state = OUTPUT;
               end
            end
         end
         OUTPUT: begin
            if (out_valid && out_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         tap_cnt   <= '0;
         taps      <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         state     <= next_state;
         in_ready  <= (next_state == ACCUM);
         out_valid <= (next_state == OUTPUT);
         busy      <= (next_state != IDLE);
         if (start_bad_c || wr_bad_c) begin
            cfg_err <= 1'b1;
         end
         if (start_ok_c) begin
            taps    <= ks_taps(ks_e'(kernel_size));
            tap_cnt <= '0;
         end else if (accept_c) begin
            tap_cnt <= tap_cnt + TAP_W'(1);
         end
      end
   end

   // Weight store is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_ok_c) begin
         wmem[wr_c.ch][wr_c.addr] <= wr_c.data;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      logic signed [OUT_W-1:0] lane_result;

      mac_lane u_lane (
         .clk    (clk),
         .reset  (reset),
         .clear  (start_ok_c),
         .en     (accept_c),
         .load   (last_c),
         .pixel  (pixel_in),
         .weight (wmem[c][tap_cnt]),
         .result (lane_result)
      );

      assign out_data[c*OUT_W +: OUT_W] = lane_result;
   end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed self-checking bench for conv_mac_engine with hand-computed window results.
module tb_conv_mac_engine;

   logic        clk;
   logic        reset;
   logic [1:0]  kernel_size;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  pixel_in;
   logic        w_we;
   logic [1:0]  w_ch;
   logic [5:0]  w_addr;
   logic [7:0]  w_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        busy;
   logic        cfg_err;

   int checks   = 0;
   int failures = 0;

   conv_mac_engine dut (
      .clk         (clk),
      .reset       (reset),
      .kernel_size (kernel_size),
      .start       (start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .pixel_in    (pixel_in),
      .w_we        (w_we),
      .w_ch        (w_ch),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy),
      .cfg_err     (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   function automatic int rl(input int v);
`ifdef CONV_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic write_w(input int ch, input int addr, input int data);
      w_we   = 1'b1;
      w_ch   = 2'(ch);
      w_addr = 6'(addr);
      w_data = 8'(data);
      @(negedge clk);
      w_we   = 1'b0;
   endtask

   task automatic set_weights(input int n, input int w0, input int w1, input int w2, input int w3);
      for (int t = 0; t < n; t++) begin
         write_w(0, t, w0);
         write_w(1, t, w1);
         write_w(2, t, w2);
         write_w(3, t, w3);
      end
   endtask

   task automatic start_win(input logic [1:0] ks);
      start       = 1'b1;
      kernel_size = ks;
      @(negedge clk);
      start       = 1'b0;
   endtask

   // Present one pixel, wait (bounded) for in_ready, then optionally idle the input.
   task automatic feed(input int p, input int gap);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      pixel_in = 8'(p);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("feed_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] snap;
      reset       = 1'b1;
      kernel_size = 2'b00;
      start       = 1'b0;
      in_valid    = 1'b0;
      pixel_in    = '0;
      w_we        = 1'b0;
      w_ch        = '0;
      w_addr      = '0;
      w_data      = '0;
      out_ready   = 1'b0;
      repeat (2) @(negedge clk);

      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cfg_err", 64'(cfg_err), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // 3x3, ch0 weights 1, pixels 1..9 at full rate; kernel_size changed after start.
      set_weights(9, 1, 0, 0, 0);
      start_win(2'b00);
      kernel_size = 2'b10;
      check("t1_busy_accum", 64'(busy), 64'd1);
      for (int i = 1; i <= 9; i++) begin
         if (i == 9) check("t1_no_early_valid", 64'(out_valid), 64'd0);
         feed(i, 0);
      end
      in_valid = 1'b0;
      check("t1_out_valid", 64'(out_valid), 64'd1);
      check("t1_out_data", out_data, pk(45, 0, 0, 0));
      check("t1_in_ready_out", 64'(in_ready), 64'd0);
      release_out();
      check("t1_done_valid", 64'(out_valid), 64'd0);
      check("t1_done_busy", 64'(busy), 64'd0);

      // Two signed lanes: ch0 weights -1, ch1 weights 2.
      set_weights(9, -1, 2, 0, 0);
      start_win(2'b00);
      for (int i = 1; i <= 9; i++) feed(i, 0);
      in_valid = 1'b0;
      check("t2_out_valid", 64'(out_valid), 64'd1);
      check("t2_out_data", out_data, pk(rl(-45), 90, 0, 0));
      release_out();

      // 7x7 saturation in both directions.
      set_weights(49, 127, -128, 127, 0);
      start_win(2'b10);
      for (int i = 0; i < 49; i++) feed(255, 0);
      in_valid = 1'b0;
      check("t3_out_valid", 64'(out_valid), 64'd1);
      check("t3_out_data", out_data, pk(32767, rl(-32768), 32767, 0));
      release_out();

      // 5x5 with gapped input, stalled output and an ignored start during OUTPUT.
      set_weights(25, 1, -1, 3, 0);
      start_win(2'b01);
      for (int i = 1; i <= 25; i++) feed(i, 1);
      check("t4_out_valid", 64'(out_valid), 64'd1);
      check("t4_out_data", out_data, pk(325, rl(-325), 975, 0));
      snap = out_data;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            start       = 1'b1;
            kernel_size = 2'b00;
         end
         @(negedge clk);
         start = 1'b0;
         check("t4_hold_data", out_data, pk(325, rl(-325), 975, 0));
         check("t4_hold_stable", out_data, snap);
         check("t4_hold_in_ready", 64'(in_ready), 64'd0);
         check("t4_hold_valid", 64'(out_valid), 64'd1);
      end
      release_out();
      check("t4_done_valid", 64'(out_valid), 64'd0);
      check("t4_no_restart", 64'(busy), 64'd0);
      check("t4_cfg_err", 64'(cfg_err), 64'd0);

      // Reset after 4 taps aborts the window; a fresh window of 2s follows.
      set_weights(9, 1, 0, 0, 0);
      start_win(2'b00);
      for (int i = 0; i < 4; i++) feed(5, 0);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      check("t5_abort_valid", 64'(out_valid), 64'd0);
      check("t5_abort_busy", 64'(busy), 64'd0);
      check("t5_abort_in_ready", 64'(in_ready), 64'd0);
      check("t5_abort_data", out_data, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("t5_idle_valid", 64'(out_valid), 64'd0);
      start_win(2'b00);
      for (int i = 1; i <= 9; i++) begin
         if (i == 9) check("t5_no_stale", 64'(out_valid), 64'd0);
         feed(2, 0);
      end
      in_valid = 1'b0;
      check("t5_out_valid", 64'(out_valid), 64'd1);
      check("t5_out_data", out_data, pk(18, 0, 0, 0));
      release_out();

      // Illegal kernel size, then a dropped weight write during ACCUM.
      start_win(2'b11);
      check("t6_cfg_err", 64'(cfg_err), 64'd1);
      check("t6_bad_busy", 64'(busy), 64'd0);
      check("t6_bad_in_ready", 64'(in_ready), 64'd0);
      start_win(2'b00);
      write_w(0, 0, 100);
      check("t6_cfg_err_hold", 64'(cfg_err), 64'd1);
      for (int i = 0; i < 9; i++) feed(1, 0);
      in_valid = 1'b0;
      check("t6_out_valid", 64'(out_valid), 64'd1);
      check("t6_out_data", out_data, pk(9, 0, 0, 0));
      release_out();
      check("t6_cfg_err_sticky", 64'(cfg_err), 64'd1);

      // Out-of-range weight address flags an error from a clean state.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("t7_cfg_err_cleared", 64'(cfg_err), 64'd0);
      write_w(0, 49, 5);
      check("t7_cfg_err_addr", 64'(cfg_err), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
